// File: rtl/cla_pkg.sv
// Shared types and constants for the L2 cache-line to memory-burst adaptor.
package cla_pkg;
  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int ADDR_WIDTH  = 32;
  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int OFFSET      = $clog2(LINE_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} cla_state_t;
  typedef logic [BURST_WIDTH-1:0] burst_t;
  typedef logic [LINE_WIDTH-1:0]  line_t;
endpackage

// File: rtl/l2_cacheline_adaptor.sv
// Converts whole-line L2 reads/write-backs into fixed-length memory bursts.
// Memory-side outputs depend only on state, beat count and latched data.
module l2_cacheline_adaptor
  import cla_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);
  localparam int CW = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  cla_state_t      state, state_nxt;
  logic [CW-1:0]   cnt;
  line_t           wr_sh;
  logic            beat_ok;
  logic            last_beat;

  // resp_i only counts while a burst is in flight
  assign beat_ok   = resp_i && ((state == RD_BURST) || (state == WR_BURST));
  assign last_beat = beat_ok && (cnt == LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (write_i)     state_nxt = WR_BURST;
        else if (read_i) state_nxt = RD_BURST;
      end
      RD_BURST, WR_BURST: if (last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (state == IDLE) cnt <= '0;
    else if (beat_ok)       cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      address_o <= '0;
    else if ((state == IDLE) && (read_i || write_i))
      address_o <= {address_i[ADDR_WIDTH-1:OFFSET], OFFSET'(0)};
  end

  // Write data leaves LSB-beat first; zeros shift in behind it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wr_sh <= '0;
    else if ((state == IDLE) && write_i)
      wr_sh <= line_i;
    else if ((state == WR_BURST) && resp_i)
      wr_sh <= {BURST_WIDTH'(0), wr_sh[LINE_WIDTH-1:BURST_WIDTH]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      line_o <= '0;
    else if ((state == RD_BURST) && resp_i)
      line_o[cnt*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
  end

  assign burst_o = wr_sh[BURST_WIDTH-1:0];
  assign read_o  = (state == RD_BURST);
  assign write_o = (state == WR_BURST);
  assign resp_o  = (state == DONE);
endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// Randomized self-checking bench: a simple memory model serves beats, and
// expectations come from line/beat slicing arithmetic on the requested data.
module tb_l2_cacheline_adaptor;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] line_i = '0, line_o;
  logic [31:0]  address_i = '0, address_o;
  logic         read_i = 1'b0, write_i = 1'b0, resp_i = 1'b0;
  logic         resp_o, read_o, write_o;
  logic [63:0]  burst_i = '0, burst_o;
  int checks = 0;
  int errors = 0;

  l2_cacheline_adaptor dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Drives one L2 request and plays memory. Gaps come from pat first, then gap_pct.
  task automatic run_op(input bit wr, input bit both, input logic [31:0] addr,
      input logic [255:0] wline, input logic [255:0] rline, input int gap_pct,
      input int pat[$], input bit chain_rd,
      output logic [255:0] wseen, output logic [255:0] lseen, output logic [31:0] aseen,
      output int nresp, output int nrd, output int nwr, output int first_act,
      output int resp_gap, output int nbeats, output bit tmo);
    int beats, cyc, last_cyc, post;
    bit done, go;
    beats = 0; cyc = 0; last_cyc = -100; post = 0; done = 0;
    wseen = '0; lseen = '0; aseen = '0; nresp = 0; nrd = 0; nwr = 0;
    first_act = -1; resp_gap = -1; tmo = 0;
    write_i = wr | both; read_i = !wr | both; address_i = addr; line_i = wline; resp_i = 0;
    while (!done) begin
      @(negedge clk); cyc++;
      if (read_o)  nrd++;
      if (write_o) nwr++;
      if ((read_o || write_o) && first_act < 0) first_act = cyc;
      if (resp_o) begin
        nresp++;
        if (resp_gap < 0) begin resp_gap = cyc - last_cyc; lseen = line_o; aseen = address_o; end
      end
      resp_i = 0;
      burst_i = {$urandom, $urandom};
      if ((read_o || write_o) && beats < 4) begin
        if (pat.size() > 0) go = (pat.pop_front() != 0);
        else                go = ($urandom_range(99) >= gap_pct);
        if (go) begin
          resp_i = 1;
          burst_i = rline[beats*64 +: 64];
          if (write_o) wseen[beats*64 +: 64] = burst_o;
          beats++;
          last_cyc = cyc;
        end
      end
      if (nresp > 0) begin
        if (post == 0) begin write_i = 0; read_i = chain_rd; end
        if (chain_rd || post == 3) done = 1;
        post++;
      end
      if (cyc > 300) begin tmo = 1; done = 1; end
    end
    resp_i = 0;
    if (!chain_rd) begin write_i = 0; read_i = 0; end
    nbeats = beats;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({line_o, burst_o, address_o, read_o, write_o, resp_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got line=%h burst=%h addr=%h rd=%b wr=%b resp=%b exp all 0",
               line_o, burst_o, address_o, read_o, write_o, resp_o);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_read();
    logic [255:0] ws, ls, rl; logic [31:0] as; int nr, nd, nw, fa, rg, nb; bit to;
    int q[$];
    rl = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    run_op(0, 0, 32'h0000_1234, '0, rl, 0, q, 0, ws, ls, as, nr, nd, nw, fa, rg, nb, to);
    checks++; if (to !== 0) begin errors++; $display("FAIL rd_timeout got %0d exp 0", to); end
    checks++; if (as !== 32'h0000_1220) begin errors++; $display("FAIL rd_addr got %h exp 00001220", as); end
    checks++; if (ls !== rl) begin errors++; $display("FAIL rd_line got %h exp %h", ls, rl); end
    checks++; if (nr !== 1 || rg !== 1) begin errors++; $display("FAIL rd_resp got cnt=%0d gap=%0d exp 1/1", nr, rg); end
    checks++; if (fa !== 1 || nd !== 4 || nw !== 0) begin errors++; $display("FAIL rd_timing got first=%0d rd=%0d wr=%0d exp 1/4/0", fa, nd, nw); end
  endtask

  task automatic test_write();
    logic [255:0] ws, ls, wl; logic [31:0] as; int nr, nd, nw, fa, rg, nb; bit to;
    int q[$];
    wl = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
          64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    run_op(1, 0, 32'hABCD_EF7F, wl, '0, 0, q, 0, ws, ls, as, nr, nd, nw, fa, rg, nb, to);
    checks++; if (ws !== wl) begin errors++; $display("FAIL wr_beats got %h exp %h", ws, wl); end
    checks++; if (as !== 32'hABCD_EF60) begin errors++; $display("FAIL wr_addr got %h exp abcdef60", as); end
    checks++; if (nr !== 1 || rg !== 1 || nw !== 4) begin errors++; $display("FAIL wr_resp got cnt=%0d gap=%0d wrcyc=%0d exp 1/1/4", nr, rg, nw); end
    checks++; if (fa !== 1 || nd !== 0 || to !== 0) begin errors++; $display("FAIL wr_timing got first=%0d rd=%0d to=%0d exp 1/0/0", fa, nd, to); end
  endtask

  task automatic test_gapped_read();
    logic [255:0] ws, ls, rl; logic [31:0] as; int nr, nd, nw, fa, rg, nb; bit to;
    int q[$];
    q = {1, 0, 0, 1, 1, 0, 1};
    rl = rand_line();
    run_op(0, 0, $urandom, '0, rl, 0, q, 0, ws, ls, as, nr, nd, nw, fa, rg, nb, to);
    checks++; if (ls !== rl) begin errors++; $display("FAIL gap_line got %h exp %h", ls, rl); end
    checks++; if (nr !== 1 || nb !== 4 || nd !== 7) begin errors++; $display("FAIL gap_count got resp=%0d beats=%0d rdcyc=%0d exp 1/4/7", nr, nb, nd); end
  endtask

  task automatic test_simultaneous();
    logic [255:0] ws, ls, wl; logic [31:0] as; int nr, nd, nw, fa, rg, nb; bit to;
    int q[$];
    wl = rand_line();
    run_op(1, 1, $urandom, wl, rand_line(), 30, q, 0, ws, ls, as, nr, nd, nw, fa, rg, nb, to);
    checks++; if (nd !== 0) begin errors++; $display("FAIL both_no_read got rdcyc=%0d exp 0", nd); end
    checks++; if (ws !== wl || nr !== 1) begin errors++; $display("FAIL both_write got %h resp=%0d exp %h resp=1", ws, nr, wl); end
  endtask

  task automatic test_random();
    logic [255:0] ws, ls, wl, rl; logic [31:0] as, ad; int nr, nd, nw, fa, rg, nb; bit to, wr;
    int q[$];
    for (int i = 0; i < 20; i++) begin
      wr = $urandom_range(1); ad = $urandom; wl = rand_line(); rl = rand_line();
      run_op(wr, 0, ad, wl, rl, 40, q, 0, ws, ls, as, nr, nd, nw, fa, rg, nb, to);
      checks++;
      if (as !== {ad[31:5], 5'b0}) begin errors++; $display("FAIL rand_addr[%0d] got %h exp %h", i, as, {ad[31:5], 5'b0}); end
      checks++;
      if (wr ? (ws !== wl) : (ls !== rl)) begin
        errors++; $display("FAIL rand_data[%0d] got %h exp %h", i, wr ? ws : ls, wr ? wl : rl);
      end
      checks++;
      if (nr !== 1 || rg !== 1 || to !== 0 || (wr ? nd : nw) !== 0) begin
        errors++; $display("FAIL rand_proto[%0d] got resp=%0d gap=%0d to=%0d other=%0d exp 1/1/0/0", i, nr, rg, to, wr ? nd : nw);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [255:0] ws, ls, rl; logic [31:0] as; int nr, nd, nw, fa, rg, nb, given, cyc; bit to;
    int q[$];
    write_i = 1; read_i = 0; address_i = $urandom; line_i = rand_line(); resp_i = 0;
    given = 0; cyc = 0;
    while (given < 2 && cyc < 50) begin
      @(negedge clk); cyc++;
      resp_i = write_o;
      if (write_o) given++;
    end
    @(negedge clk); resp_i = 0;
    #2 rst = 1;
    #1;
    checks++;
    if ({line_o, burst_o, address_o, read_o, write_o, resp_o} !== '0 || given != 2) begin
      errors++;
      $display("FAIL async_rst got line=%h burst=%h addr=%h rd=%b wr=%b resp=%b beats=%0d exp 0, 2 beats",
               line_o, burst_o, address_o, read_o, write_o, resp_o, given);
    end
    write_i = 0;
    @(negedge clk);
    rst = 0;
    rl = rand_line();
    run_op(0, 0, 32'h0000_0040, '0, rl, 20, q, 0, ws, ls, as, nr, nd, nw, fa, rg, nb, to);
    checks++;
    if (ls !== rl || nr !== 1 || fa !== 1 || nw !== 0 || as !== 32'h0000_0040) begin
      errors++; $display("FAIL post_rst_read got %h resp=%0d first=%0d wr=%0d addr=%h exp %h 1/1/0/00000040", ls, nr, fa, nw, as, rl);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] ws, ls, wl, rl; logic [31:0] as; int nr, nd, nw, fa, rg, nb; bit to;
    int q[$];
    wl = rand_line(); rl = rand_line();
    run_op(1, 0, $urandom, wl, '0, 0, q, 1, ws, ls, as, nr, nd, nw, fa, rg, nb, to);
    checks++; if (ws !== wl || nr !== 1) begin errors++; $display("FAIL b2b_write got %h resp=%0d exp %h resp=1", ws, nr, wl); end
    run_op(0, 0, $urandom, '0, rl, 0, q, 0, ws, ls, as, nr, nd, nw, fa, rg, nb, to);
    checks++; if (nw !== 0) begin errors++; $display("FAIL b2b_no_rewrite got wrcyc=%0d exp 0", nw); end
    checks++; if (fa !== 2 || ls !== rl || nr !== 1) begin errors++; $display("FAIL b2b_read got first=%0d line=%h resp=%0d exp 2 %h 1", fa, ls, nr, rl); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_gapped_read();
    test_simultaneous();
    test_random();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
